out_bit_sequencer: RTL and testbench
====================================

OUT_BIT_SEQUENCER -- requirements
Module: out_bit_sequencer

Interface
REQ-001 The block SHALL have exactly one clock domain and no parameters.
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- reqValid  input  1  byte write request valid.
- reqReady  output  1  block can accept a request.
- reqData  input  8  byte value to write.
- reqMask  input  8  per-bit write enable; bit i set means output bit i is written.
- writeDisable  input  1  downstream write inhibit (shared with output selector).
- data  output  1  bit value presented to the output selector.
- write  output  1  write strobe to the output selector.
- CE  output  1  chip enable to the output selector.
- addr  output  3  bit index to the output selector.
- busy  output  1  request in progress.
- done  output  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-004 reqReady SHALL be 1 only in IDLE; a request is accepted on a rising clk edge with reqValid=1 and reqReady=1.
REQ-005 On acceptance, the block SHALL latch reqData into dataReg and reqMask into pendReg, with these transitions:
- reqMask != 0 -> RUN.
- reqMask == 0 -> DONE.
REQ-006 In RUN, the block SHALL compute idx as the lowest set bit of pendReg, which is combinational and priority LSB-first.
REQ-007 In RUN, the outputs SHALL be:
- CE = 1.
- addr = idx.
- data = dataReg[idx].
- write = ~writeDisable (combinational path).
REQ-008 Outside RUN, the outputs SHALL be CE=0, write=0, addr=0 and data=0.
REQ-009 On each RUN edge with writeDisable=0, the block SHALL clear pendReg[idx].
- If pendReg becomes 0 -> DONE.
- Otherwise, stay in RUN.
REQ-010 On a RUN edge with writeDisable=1, the block SHALL hold pendReg, idx and the state (stall with no timeout).
REQ-011 DONE SHALL last exactly one cycle with done=1, then -> IDLE unconditionally.
REQ-012 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-013 Latency: for a request accepted at edge N with k set mask bits and no stalls:
- Write cycles N+1..N+k.
- done in cycle N+k+1.
- reqReady=1 in cycle N+k+2.
REQ-014 For a request accepted at edge N with mask 0, done SHALL be high in cycle N+1.
REQ-015 Masked-off bits SHALL consume no cycles, and bit order SHALL always be ascending addr.
REQ-016 reqData and reqMask changes after acceptance SHALL have no effect until the next acceptance.
REQ-017 reqValid asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-018 A writeDisable toggle mid-sequence SHALL only delay the sequence; no bit is skipped or written twice.
REQ-019 done and reqReady SHALL never be 1 in the same cycle.

Reset
REQ-020 rst=0 SHALL asynchronously force:
- state = IDLE, pendReg = 0, dataReg = 0.
- All outputs 0, except reqReady=1.
REQ-021 Reset mid-RUN SHALL abandon the remaining bits, with no done pulse.
REQ-022 The first acceptance after rst deasserts SHALL occur on the first rising edge with rst=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- reqData=8'hA5, reqMask=8'hFF, writeDisable=0 -> addr 0..7 on 8 consecutive cycles; data sequence 1,0,1,0,0,1,0,1; done in cycle 9 after accept.
- reqData=8'hFF, reqMask=8'h81 -> exactly two write cycles (addr 0, then addr 7), then done.
- reqMask=8'h00 -> no write/CE asserted; done in the cycle after accept; reqReady back the cycle after.
- reqMask=8'h0F with writeDisable=1 for 3 cycles during addr=2 -> write=0 and addr=2 held for 3 cycles, CE=1; addr 2 and addr 3 each written once; done 3 cycles later than unstalled.
- rst=0 pulsed while addr=4 of mask 8'hFF -> outputs 0 immediately; reqReady=1; no done; next request runs from addr 0.
- reqValid held high continuously -> back-to-back requests are accepted only in IDLE; each completes with exactly one done pulse.

Source files
------------

// File: rtl/out_bit_sequencer.sv
// Byte-to-bit write sequencer: walks the set bits of a write mask LSB-first
// and presents one (addr, data) bit per cycle to the output selector.
module out_bit_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       reqValid,
   output logic       reqReady,
   input  logic [7:0] reqData,
   input  logic [7:0] reqMask,
   input  logic       writeDisable,
   output logic       data,
   output logic       write,
   output logic       CE,
   output logic [2:0] addr,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [7:0] pend_q, pend_d;
   logic [2:0] idx;
   logic       in_run;

   // Lowest pending bit wins, so bits always leave in ascending address order.
   always_comb begin
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i]) idx = 3'(i);
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      pend_d  = pend_q;
      case (state_q)
         IDLE: begin
            if (reqValid) begin
               data_d  = reqData;
               pend_d  = reqMask;
               state_d = (reqMask == 8'h00) ? DONE : RUN;
            end
         end
         RUN: begin
            // writeDisable stalls the sequence in place; the bit is retried.
            if (!writeDisable) begin
               pend_d[idx] = 1'b0;
               if ((pend_q & ~(8'h01 << idx)) == 8'h00) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= 8'h00;
         pend_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         pend_q  <= pend_d;
      end
   end

   assign in_run   = (state_q == RUN);
   assign reqReady = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign CE       = in_run;
   assign addr     = in_run ? idx : 3'd0;
   assign data     = in_run ? data_q[idx] : 1'b0;
   assign write    = in_run & ~writeDisable;

endmodule

// File: tb/tb_out_bit_sequencer.sv
// Scoreboard bench: the driver queues expected writes/done pulses per request,
// a negedge monitor pops and compares them whenever write or done is seen.
module tb_out_bit_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       reqValid = 1'b0;
   logic       reqReady;
   logic [7:0] reqData = 8'h00;
   logic [7:0] reqMask = 8'h00;
   logic       writeDisable = 1'b0;
   logic       data, write, CE, busy, done;
   logic [2:0] addr;

   typedef struct {
      bit         is_done;
      logic [2:0] a;
      logic       d;
      int         cyc;
   } exp_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   out_bit_sequencer dut (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
      .reqData(reqData), .reqMask(reqMask), .writeDisable(writeDisable),
      .data(data), .write(write), .CE(CE), .addr(addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expectation per observed write strobe or done pulse.
   always @(negedge clk) begin
      if (rst) begin
         if (write) begin
            if (sbq.size() == 0 || sbq[0].is_done) begin
               chk("unexpected_write", {29'd0, addr}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("write_addr", {29'd0, addr}, {29'd0, e.a});
               chk("write_data", {31'd0, data}, {31'd0, e.d});
               chk("write_cyc", cyc, e.cyc);
            end
         end
         if (done) begin
            if (sbq.size() == 0 || !sbq[0].is_done) begin
               chk("unexpected_done", cyc, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("done_cyc", cyc, e.cyc);
            end
         end
         if (done && reqReady) chk("done_and_ready", 32'd1, 32'd0);
         if (CE !== (busy && !done)) chk("ce_only_in_run", {31'd0, CE}, {31'd0, busy && !done});
      end
   end

   // Issue one request; inputs are driven 1 time unit after the rising edge.
   task automatic send(input logic [7:0] d, input logic [7:0] m, input bit hold,
                       input int stall_at, input int stall_len, input int abort_at);
      int n, c, t;
      bit rb, wd;
      logic [2:0] stall_addr;
      reqData = d; reqMask = m; reqValid = 1'b1;
      t = 0;
      forever begin
         rb = reqReady;
         @(posedge clk); #1;
         if (rb) break;
         t++;
         if (t > 40) begin
            chk("accept_timeout", t, 0);
            reqValid = 1'b0;
            return;
         end
      end
      n = cyc;
      reqValid = hold;
      reqData = ~d;
      reqMask = ~m;
      c = n;
      stall_addr = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            if (stall_len > 0 && c - n == stall_at) begin
               c += stall_len;
               stall_addr = 3'(i);
            end
            sbq.push_back('{1'b0, 3'(i), d[i], c});
            c++;
         end
      end
      sbq.push_back('{1'b1, 3'd0, 1'b0, c});
      while (cyc < c + 1) begin
         if (abort_at > 0 && cyc == n + abort_at) begin
            chk("pre_abort_addr", {29'd0, addr}, 32'd4);
            rst = 1'b0;
            #1;
            chk("abort_write", {31'd0, write}, 32'd0);
            chk("abort_ce", {31'd0, CE}, 32'd0);
            chk("abort_addr", {29'd0, addr}, 32'd0);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk("abort_ready", {31'd0, reqReady}, 32'd1);
            sbq.delete();
            #2;
            rst = 1'b1;
            return;
         end
         wd = (stall_len > 0) && (cyc >= n + stall_at) && (cyc < n + stall_at + stall_len);
         writeDisable = wd;
         if (wd) begin
            #1;
            chk("stall_write", {31'd0, write}, 32'd0);
            chk("stall_ce", {31'd0, CE}, 32'd1);
            chk("stall_addr", {29'd0, addr}, {29'd0, stall_addr});
         end
         @(posedge clk); #1;
      end
      writeDisable = 1'b0;
      chk("ready_after_done", {31'd0, reqReady}, 32'd1);
      chk("done_low_in_idle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #1 rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, reqReady}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_write", {31'd0, write}, 32'd0);
      chk("rst_ce", {31'd0, CE}, 32'd0);
      chk("rst_addr_data", {28'd0, addr, data}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      send(8'hA5, 8'hFF, 1'b0, 0, 0, 0);   // full byte, data 1,0,1,0,0,1,0,1
      send(8'hFF, 8'h81, 1'b0, 0, 0, 0);   // only addr 0 and 7
      send(8'h5A, 8'h00, 1'b0, 0, 0, 0);   // empty mask: done straight away
      send(8'h0A, 8'h0F, 1'b0, 2, 3, 0);   // stall 3 cycles on addr 2
      send(8'h33, 8'hFF, 1'b0, 0, 0, 4);   // reset while addr 4 is presented
      send(8'h96, 8'hFF, 1'b0, 0, 0, 0);   // restart from addr 0 after reset
      send(8'h3C, 8'h06, 1'b1, 0, 0, 0);   // reqValid held: back-to-back
      send(8'h5A, 8'h90, 1'b1, 0, 0, 0);
      send(8'hC3, 8'h00, 1'b1, 0, 0, 0);
      reqValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      chk("final_idle", {31'd0, reqReady}, 32'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
